// File: rtl/phys_reg_free_list.sv
// -----------------------------------------------------------------------------
// phys_reg_free_list
//
// Allocation controller for the physical register pool behind the renaming
// register file. Free physical tags sit in a circular FIFO. Rename takes one
// tag per cycle from the head, and retirement returns one tag per cycle at the
// tail. At each conditional branch a checkpoint saves the head pointer. On a
// mispredict the head rolls back to that checkpoint, so the tags taken on the
// wrong path become free again.
//
// Optional build macro:
//   FREE_LIST_BYPASS_EN - when the list is empty, a tag being freed in the
//                         same cycle is granted straight to rename.
//
// Ports:
//   clk              clock; all state updates on the rising edge
//   rst_n            asynchronous active-low reset
//   alloc_req_i      rename needs a destination tag this cycle
//   alloc_gnt_o      a tag is available (allocation = req && gnt)
//   alloc_tag_o      tag at the FIFO head, valid when alloc_gnt_o
//   free_valid_i     retirement releases free_tag_i
//   free_tag_i       released tag
//   ckpt_req_i       take a branch checkpoint
//   ckpt_id_o        id given to a checkpoint taken this cycle
//   ckpt_full_o      all checkpoint slots are outstanding
//   ckpt_release_i   oldest branch resolved correctly; drop the oldest checkpoint
//   restore_valid_i  mispredict; roll back to checkpoint restore_id_i
//   restore_id_i     checkpoint to restore
//   free_count_o     number of tags currently in the FIFO
//   proto_err_o      sticky protocol-error flag
// -----------------------------------------------------------------------------
module phys_reg_free_list #(
  parameter int PHYS_REGS  = 64,
  parameter int ARCH_REGS  = 32,
  parameter int CKPT_DEPTH = 4,
  localparam int TAG_W     = $clog2(PHYS_REGS),
  localparam int CID_W     = $clog2(CKPT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req_i,
  output logic             alloc_gnt_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             free_valid_i,
  input  logic [TAG_W-1:0] free_tag_i,
  input  logic             ckpt_req_i,
  output logic [CID_W-1:0] ckpt_id_o,
  output logic             ckpt_full_o,
  input  logic             ckpt_release_i,
  input  logic             restore_valid_i,
  input  logic [CID_W-1:0] restore_id_i,
  output logic [TAG_W:0]   free_count_o,
  output logic             proto_err_o
);

  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FL_AW    = $clog2(FL_DEPTH);
  localparam int PTR_W    = FL_AW + 1;   // FIFO pointer with wrap bit
  localparam int CP_W     = CID_W + 1;   // checkpoint pointer with wrap bit

  logic [TAG_W-1:0] fifo_q  [FL_DEPTH];
  logic [PTR_W-1:0] saved_q [CKPT_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CP_W-1:0]  c_head_q, c_head_d, c_tail_q, c_tail_d;
  logic             err_q, err_d;

  logic [PTR_W-1:0] cnt, head_adv;
  logic [CP_W-1:0]  c_cnt, restore_pos;
  logic [CID_W-1:0] rel_off;
  logic             fl_empty, fl_full, c_empty, c_full;
  logic             restore_ok, restore_do;
  logic             bypass, handoff, alloc_fire, free_push, ckpt_push, ckpt_pop;

  always_comb begin
    cnt      = tail_q - head_q;
    fl_empty = (cnt == '0);
    fl_full  = (cnt == PTR_W'(FL_DEPTH));
    c_cnt    = c_tail_q - c_head_q;
    c_empty  = (c_cnt == '0);
    c_full   = (c_cnt == CP_W'(CKPT_DEPTH));

    // A restore id is valid only if it is within the outstanding window,
    // measured as an offset from the oldest checkpoint.
    rel_off     = restore_id_i - c_head_q[CID_W-1:0];
    restore_ok  = (CP_W'(rel_off) < c_cnt);
    restore_do  = restore_valid_i && restore_ok;
    restore_pos = c_head_q + CP_W'(rel_off);

`ifdef FREE_LIST_BYPASS_EN
    bypass = fl_empty && free_valid_i;
`else
    bypass = 1'b0;
`endif

    alloc_gnt_o = !fl_empty || bypass;
    alloc_tag_o = bypass ? free_tag_i : fifo_q[head_q[FL_AW-1:0]];

    // On a handoff the freed tag goes straight to rename and never enters
    // the FIFO.
    handoff    = bypass && alloc_req_i && !restore_do;
    alloc_fire = alloc_req_i && !fl_empty && !restore_do;
    free_push  = free_valid_i && !fl_full && !handoff;
    ckpt_push  = ckpt_req_i && !c_full && !restore_do;
    ckpt_pop   = ckpt_release_i && !c_empty && !restore_valid_i;

    // A checkpoint captures the head after this cycle's allocation.
    head_adv = head_q + PTR_W'(alloc_fire);
    head_d   = restore_do ? saved_q[restore_id_i] : head_adv;
    tail_d   = tail_q + PTR_W'(free_push);
    c_tail_d = restore_do ? restore_pos : (c_tail_q + CP_W'(ckpt_push));
    c_head_d = c_head_q + CP_W'(ckpt_pop);

    err_d = err_q
          | (free_valid_i && fl_full)
          | (ckpt_req_i && c_full && !restore_do)
          | (ckpt_release_i && (c_empty || restore_valid_i))
          | (restore_valid_i && !restore_ok);

    ckpt_id_o    = c_tail_q[CID_W-1:0];
    ckpt_full_o  = c_full;
    free_count_o = (TAG_W+1)'(cnt);
    proto_err_o  = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= PTR_W'(FL_DEPTH);
      c_head_q <= '0;
      c_tail_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < FL_DEPTH; i++) begin
        fifo_q[i] <= TAG_W'(ARCH_REGS + i);
      end
      for (int j = 0; j < CKPT_DEPTH; j++) begin
        saved_q[j] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      c_head_q <= c_head_d;
      c_tail_q <= c_tail_d;
      err_q    <= err_d;
      if (free_push) begin
        fifo_q[tail_q[FL_AW-1:0]] <= free_tag_i;
      end
      if (ckpt_push) begin
        saved_q[c_tail_q[CID_W-1:0]] <= head_adv;
      end
    end
  end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
Allocation controller for the 64-entry physical register pool used by the renaming register file.
- Holds free physical tags in a circular FIFO.
- Grants one tag per cycle to decode/rename.
- Reclaims one tag per cycle from retirement.
- Checkpoints the allocation pointer at each conditional branch and rolls it back on mispredict, so tags allocated on the wrong path return to the pool.

Parameters:
PHYS_REGS, 64, number of physical registers; TAG_W = $clog2(PHYS_REGS)
ARCH_REGS, 32, architectural registers; tags 0..ARCH_REGS-1 are mapped at reset and never in the initial free list
CKPT_DEPTH, 4, maximum outstanding branch checkpoints; CID_W = $clog2(CKPT_DEPTH)

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
alloc_req  in  1  rename needs a destination tag this cycle
alloc_gnt  out  1  tag available; allocation occurs when alloc_req && alloc_gnt
alloc_tag  out  TAG_W  tag at FIFO head, valid when alloc_gnt
free_valid  in  1  retirement releases a tag
free_tag  in  TAG_W  released tag
ckpt_req  in  1  take checkpoint (conditional branch renamed)
ckpt_id  out  CID_W  id assigned to a checkpoint taken this cycle
ckpt_full  out  1  CKPT_DEPTH checkpoints outstanding
ckpt_release  in  1  oldest branch resolved correct; drop oldest checkpoint
restore_valid  in  1  mispredict; roll back to checkpoint restore_id
restore_id  in  CID_W  checkpoint to restore
free_count  out  TAG_W+1  tags currently in FIFO
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - rst_n is asynchronous, active-low.
- FIFO structure:
  - Depth FL_DEPTH = PHYS_REGS-ARCH_REGS (32), which must be a power of 2.
  - head/tail pointers carry an extra wrap bit (TAG_W bits for the default parameters).
  - free_count = tail - head.
- Reset state:
  - FIFO slot i holds tag ARCH_REGS+i.
  - head=0, tail=FL_DEPTH, free_count=32.
  - alloc_gnt=1, alloc_tag=32.
  - ckpt_id=0, ckpt_full=0, proto_err=0.
  - Checkpoint ring empty.
  - Reset mid-operation discards all checkpoints and in-flight state immediately.
- Allocation:
  - alloc_gnt = (free_count != 0) and is combinational from registered state; no same-cycle bypass by default.
  - alloc_tag = fifo[head], a zero-latency read.
  - On alloc_req && alloc_gnt, head advances by 1 at the clock edge.
  - alloc_req while empty has no effect; rename must stall.
- Free:
  - On free_valid, fifo[tail] <= free_tag and tail advances by 1.
  - If free_count==FL_DEPTH, the free is dropped and proto_err is set.
  - An alloc and a free in the same cycle both apply; free_count is unchanged.
- Checkpoint ring:
  - CKPT_DEPTH entries with pointers c_head (oldest) and c_tail (next free), each with a wrap bit.
  - ckpt_id = c_tail[CID_W-1:0].
  - ckpt_full = (c_tail - c_head == CKPT_DEPTH).
- Checkpoint capture:
  - On ckpt_req && !ckpt_full, saved_head[c_tail] <= head after this cycle's allocation, then c_tail++.
  - ckpt_req while ckpt_full is ignored and sets proto_err.
- Checkpoint release:
  - ckpt_release with ring non-empty: c_head++.
  - Release on an empty ring sets proto_err.
- Restore:
  - restore_valid sets head <= saved_head[restore_id].
  - It also sets c_tail to the restore_id position, discarding the restored checkpoint and all younger ones.
  - restore_id outside the outstanding range sets proto_err; no state change.
- Restore priority:
  - In the same cycle, restore overrides alloc and ckpt_req.
  - A same-cycle free is still enqueued.
  - A same-cycle ckpt_release is ignored and sets proto_err.
- Restore count:
  - free_count after restore = tail_next - saved_head.
  - Wrap is handled by pointer subtraction modulo 2*FL_DEPTH.
- No duplicate checking of free_tag is performed.

Optional Feature:
FREE_LIST_BYPASS_EN:
- Defined:
  - When free_count==0 and free_valid, alloc_gnt=1 and alloc_tag=free_tag in the same cycle.
  - If alloc_req is also asserted, the tag is handed off directly and neither head nor tail moves.
  - Otherwise the tag is enqueued normally.
- Undefined: alloc_gnt depends only on registered free_count.

Test Plan:
- Reset, then alloc_req held 32 cycles -> tags 32..63 granted in order; free_count 0; cycle 33 alloc_gnt=0.
- From empty, free_valid with tag 5, then alloc_req -> next cycle alloc_tag=5, gnt=1. With FREE_LIST_BYPASS_EN, the same-cycle alloc gets 5 and free_count stays 0.
- Allocate 3 (32,33,34), ckpt_req -> ckpt_id 0. Allocate 35,36, then restore_valid id 0 -> free_count=29, alloc_tag=35, ckpt ring empty.
- Simultaneous alloc_req and free_valid (tag 7) at free_count=10 -> free_count stays 10; tag 7 is returned after the 10 queued tags.
- ckpt_req 4 times -> ids 0,1,2,3, ckpt_full=1; 5th ckpt_req -> ignored, proto_err=1. ckpt_release -> ckpt_full=0, next ckpt_id=0.
- Free 32 tags into a full list -> dropped, proto_err=1. Deassert then reassert rst_n mid-stream -> free_count=32, alloc_tag=32, proto_err=0 asynchronously.
